pwm_duty_ramp: RTL
==================

// Module: pwm_duty_ramp
// PURPOSE
//   Soft-start/soft-stop stage directly upstream of pwm; drives its duty_cycle input.
//   Accepts a target duty over valid/ready and slews duty_cycle toward it by STEP.
//   Updates only on PWM period boundaries, so pwm never sees a mid-period change.
//   Runs its own period counter, which stays aligned with pwm when both share clk/rst/enable.
// PARAMETERS
//   DUTY_W            8  duty/counter width; PWM period = 2**DUTY_W cycles
//   STEP              4  duty increment/decrement per update; 1..2**DUTY_W-1 (0 illegal)
//   PERIODS_PER_STEP  1  PWM periods between duty updates; >=1
// PORTS
//   clk           in   1       system clock (100 MHz in bench)
//   rst           in   1       synchronous, active-high reset
//   enable        in   1       same signal fed to pwm; low freezes counter and ramp
//   target_duty   in   DUTY_W  requested final duty
//   target_valid  in   1       target_duty valid
//   target_ready  out  1       block accepts a target (= state IDLE, combinational)
//   duty_cycle    out  DUTY_W  registered duty to pwm.duty_cycle
//   period_start  out  1       1-cycle pulse when period counter==0 and enable
//   ramping       out  1       state is RAMP_UP or RAMP_DOWN
//   done          out  1       1-cycle pulse when duty_cycle reaches an accepted target
// BEHAVIOUR
//   Reset (edge with rst=1): state=IDLE, duty_cycle=0, period cnt=0, step cnt=0, done=0.
//   After reset: target_ready=1, ramping=0; period_start follows enable.
//   Period counter: DUTY_W bits, +1 per cycle while enable; wraps 2**DUTY_W-1 -> 0.
//   Boundary: edge where counter wraps; step cnt +1, applies step when == PERIODS_PER_STEP-1, then clears.
//   FSM IDLE: on valid&&ready latch target; clear step cnt;
//     target>duty -> RAMP_UP; target<duty -> RAMP_DOWN; equal -> done next cycle, stay IDLE.
//   FSM RAMP_UP: on step: duty = min(duty+STEP, target), computed DUTY_W+1 bits, no wrap.
//   FSM RAMP_DOWN: on step: duty = max(duty-STEP, target), signed/extended compare, no underflow.
//   Ramp completes when new duty==target: done=1 that cycle (registered), state -> IDLE same edge.
//   New duty_cycle is visible in the cycle where counter==0, aligned with pwm period restart.
//   Target accepted on a boundary edge: no step on that boundary; first step at next qualifying one.
//   target_valid while ramping: ignored (ready=0); source holds it until accepted.
//   enable=0: counter, step cnt and duty hold; no period_start; handshake still allowed in IDLE.
//   rst mid-ramp: next edge duty_cycle=0, IDLE; pending target discarded.
//   done and period_start never assert during rst.
// STRUCTURE
//   Shared package pwm_pkg: DUTY_W constant, ramp state typedef (IDLE, RAMP_UP, RAMP_DOWN).
//   Sub-module pwm_period_counter: enable-gated DUTY_W-bit counter with wrap pulse.
//   pwm reuses pwm_period_counter so both counters are identical by construction.
//   Top: FSM, target register, step counter, saturating step arithmetic.
// TESTING (defaults; 1 period = 256 cycles = 2560 ns)
//   1 Reset 2 cycles -> duty_cycle=0, ramping=0, done=0, target_ready=1.
//   2 target 64 from 0 -> duty 4,8,..,64 on 16 successive boundaries; done pulses once with 64; IDLE.
//   3 from 64, target 10 -> 60,56,..,12 then 10 (clamped); done; no underflow.
//   4 at 64, target 64 -> done 1 cycle after accept; duty unchanged; ramping stays 0.
//   5 ramp to 128, enable=0 for 3 periods at duty 32 -> duty holds 32, no period_start; resumes 36.
//   6 rst mid-ramp at duty 40 -> duty 0, IDLE; target_valid pulse while ramping is not accepted.

Source files
------------

// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
//   Shared definitions for the PWM block and its duty-ramp front end.
//   - DUTY_W_DEFAULT : default duty / period-counter width (period = 2**W cycles)
//   - ramp_state_e   : ramp controller states
// -----------------------------------------------------------------------------
package pwm_pkg;

   localparam int DUTY_W_DEFAULT = 8;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RAMP_UP   = 2'd1,
      RAMP_DOWN = 2'd2
   } ramp_state_e;

endpackage : pwm_pkg

// File: rtl/pwm_period_counter.sv
// -----------------------------------------------------------------------------
// pwm_period_counter
//   Enable-gated free-running DUTY_W-bit period counter. Used by both pwm and
//   pwm_duty_ramp so the two counters stay identical and aligned when they
//   share clk/rst/enable.
// Ports
//   clk       in   system clock
//   rst       in   synchronous active-high reset (counter -> 0)
//   enable_i  in   count enable; low freezes the counter
//   cnt_o     out  current count value
//   wrap_o    out  high in the cycle whose rising edge wraps 2**W-1 -> 0
// -----------------------------------------------------------------------------
module pwm_period_counter #(
   parameter int DUTY_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable_i,
   output logic [DUTY_W-1:0] cnt_o,
   output logic              wrap_o
);

   logic [DUTY_W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (enable_i) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign cnt_o  = cnt_q;
   assign wrap_o = enable_i && (cnt_q == '1);

endmodule : pwm_period_counter

// File: rtl/pwm_duty_ramp.sv
// -----------------------------------------------------------------------------
// pwm_duty_ramp
//   Soft-start / soft-stop stage feeding pwm.duty_cycle. Accepts a target duty
//   over a valid/ready handshake and slews duty_cycle toward it by STEP, only
//   on PWM period boundaries, so the new duty appears exactly when the PWM
//   period restarts (counter == 0).
// Ports
//   clk           in   system clock
//   rst           in   synchronous active-high reset
//   enable        in   same enable as pwm; low freezes counter and ramp
//   target_duty   in   requested final duty
//   target_valid  in   target_duty valid
//   target_ready  out  high while IDLE (combinational)
//   duty_cycle    out  registered duty to pwm
//   period_start  out  high while counter == 0 and enabled
//   ramping       out  high in RAMP_UP / RAMP_DOWN
//   done          out  1-cycle pulse when duty_cycle reaches the accepted target
// -----------------------------------------------------------------------------
module pwm_duty_ramp
   import pwm_pkg::*;
#(
   parameter int DUTY_W           = DUTY_W_DEFAULT,
   parameter int STEP             = 4,
   parameter int PERIODS_PER_STEP = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic [DUTY_W-1:0] target_duty,
   input  logic              target_valid,
   output logic              target_ready,
   output logic [DUTY_W-1:0] duty_cycle,
   output logic              period_start,
   output logic              ramping,
   output logic              done
);

   localparam int SC_W = (PERIODS_PER_STEP > 1) ? $clog2(PERIODS_PER_STEP) : 1;
   localparam logic [SC_W-1:0]   SC_LAST = SC_W'(PERIODS_PER_STEP - 1);
   localparam logic [DUTY_W:0]   STEP_X  = (DUTY_W + 1)'(STEP);

   ramp_state_e       state_q;
   logic [DUTY_W-1:0] duty_q;
   logic [DUTY_W-1:0] target_q;
   logic [SC_W-1:0]   step_cnt_q;
   logic              done_q;

   logic [DUTY_W-1:0] cnt;
   logic              wrap;

   pwm_period_counter #(
      .DUTY_W (DUTY_W)
   ) u_period_counter (
      .clk      (clk),
      .rst      (rst),
      .enable_i (enable),
      .cnt_o    (cnt),
      .wrap_o   (wrap)
   );

   // Saturating step arithmetic, one bit wider than the duty so neither the
   // upward sum nor the downward comparison can wrap.
   logic [DUTY_W:0]   duty_x;
   logic [DUTY_W:0]   target_x;
   logic [DUTY_W:0]   sum_up;
   logic [DUTY_W:0]   floor_dn;
   logic [DUTY_W-1:0] up_val;
   logic [DUTY_W-1:0] dn_val;
   logic [DUTY_W-1:0] step_d;

   assign duty_x   = {1'b0, duty_q};
   assign target_x = {1'b0, target_q};
   assign sum_up   = duty_x + STEP_X;
   // duty - STEP <= target  <=>  duty <= target + STEP (no negative values needed)
   assign floor_dn = target_x + STEP_X;
   assign up_val   = (sum_up >= target_x) ? target_q : sum_up[DUTY_W-1:0];
   assign dn_val   = (duty_x <= floor_dn) ? target_q : (duty_q - STEP_X[DUTY_W-1:0]);
   assign step_d   = (state_q == RAMP_UP) ? up_val : dn_val;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         duty_q     <= '0;
         target_q   <= '0;
         step_cnt_q <= '0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (target_valid) begin
                  target_q   <= target_duty;
                  step_cnt_q <= '0;
                  if (target_duty > duty_q) begin
                     state_q <= RAMP_UP;
                  end else if (target_duty < duty_q) begin
                     state_q <= RAMP_DOWN;
                  end else begin
                     done_q <= 1'b1;
                  end
               end
            end
            RAMP_UP, RAMP_DOWN: begin
               // wrap is already gated by enable, so a frozen counter freezes the ramp
               if (wrap) begin
                  if (step_cnt_q == SC_LAST) begin
                     step_cnt_q <= '0;
                     duty_q     <= step_d;
                     if (step_d == target_q) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                     end
                  end else begin
                     step_cnt_q <= step_cnt_q + 1'b1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign target_ready = (state_q == IDLE);
   assign ramping      = (state_q == RAMP_UP) || (state_q == RAMP_DOWN);
   assign duty_cycle   = duty_q;
   assign done         = done_q && !rst;
   assign period_start = enable && (cnt == '0) && !rst;

endmodule : pwm_duty_ramp
